frame_buffer: RTL and testbench
===============================

Name: frame_buffer

Overview:
- Parametrised pixel frame store between the UART pixel receiver (write side) and the VGA timing/display path (read side).
- Write side: streaming valid/ready interface with an auto-incrementing raster pointer and a start-of-frame restart.
- Read side: (x, y) coordinates with a fixed 2-cycle pipeline; out-of-range coordinates return a background colour.
- Storage is inferred block RAM in a sub-module.

Parameters:
- PIX_W, 12, bits per pixel (RGB 4:4:4 default)
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- X_W, 9, width of rd_x (must satisfy 2**X_W >= H_RES)
- Y_W, 8, width of rd_y (must satisfy 2**Y_W >= V_RES)
- BG_COLOR, 12'h000, PIX_W-wide value returned for out-of-range reads
- WRAP, 1, 1 = write pointer wraps and keeps accepting; 0 = stop after one frame until wr_sof
- Derived localparams: DEPTH = H_RES*V_RES; ADDR_W = $clog2(DEPTH)

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- wr_sof  in  1  start of frame; restarts the write pointer
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  block can accept a pixel
- wr_data  in  PIX_W  pixel to store
- wr_frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted
- rd_en  in  1  read request
- rd_x  in  X_W  column
- rd_y  in  Y_W  row
- rd_valid  out  1  rd_data holds a new result
- rd_data  out  PIX_W  pixel read

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, full=0, wr_ready=1, wr_frame_done=0, rd_valid=0, rd_data=0, pipeline valids=0. RAM contents are not reset.
- wr_ready = ~full.
- Accept = wr_valid & wr_ready. On accept: RAM[wr_ptr] <= wr_data.
  - If wr_ptr == DEPTH-1: wr_ptr <= 0, wr_frame_done pulses next cycle, and full <= ~WRAP.
  - Otherwise: wr_ptr <= wr_ptr+1.
- wr_sof (any cycle) clears full and sets wr_ptr to 0.
  - wr_sof with an accept in the same cycle: the pixel is written at address 0 and wr_ptr becomes 1.
  - wr_sof in a cycle where full=1: no write occurs that cycle; the write is accepted from the next cycle.
- wr_valid while wr_ready=0: ignored, no write, pointer unchanged.
- Read stage 1 (on rd_en):
  - register addr = rd_y*H_RES + rd_x (ADDR_W bits, no truncation of in-range values);
  - register oob = (rd_x >= H_RES) | (rd_y >= V_RES);
  - v1 <= rd_en.
- Read stage 2: RAM registered read of addr; v2 <= v1; oob delayed alongside.
- Output: rd_valid = v2. When v2=1, rd_data = oob ? BG_COLOR : RAM output; otherwise rd_data holds its last value.
  - Latency: rd_en in cycle N gives rd_valid and rd_data in cycle N+2.
  - Full throughput: one read per cycle.
- Read and write to the same address in the same cycle: read returns the old data (read-first).
- Reset mid-frame or mid-read: the pipeline is flushed; rd_valid stays 0 until 2 cycles after the next rd_en.

Decomposition:
- Shared package/header fb_pkg holds:
  - default resolution constants (H_RES, V_RES);
  - BG_COLOR default;
  - RD_LATENCY = 2, used by the display timing block to delay sync signals.
- One sub-module: fb_ram, a simple dual-port RAM (one sync write port, one registered read port, DEPTH x PIX_W). It contains no reset logic so synthesis infers BRAM.

Test Plan (H_RES=4, V_RES=3, PIX_W=12):
- Stream 12 pixels 12'h001..12'h00C with wr_valid held high -> wr_frame_done pulses once, the cycle after 12'h00C is accepted. Then read (x=3, y=2) -> rd_data = 12'h00C, rd_valid 2 cycles after rd_en.
- WRAP=0: after 12 writes, wr_ready=0 and a 13th pixel 12'hFFF is ignored; (0,0) still reads 12'h001. Pulse wr_sof -> wr_ready=1, and the next write lands at address 0.
- Read (x=4, y=0) and (x=0, y=3) -> rd_data = BG_COLOR for both, with rd_valid asserted.
- Back-to-back reads (0,0), (1,0), (2,0) on consecutive cycles -> 12'h001, 12'h002, 12'h003 on consecutive cycles; rd_data holds 12'h003 after rd_en drops.
- Write 12'hABC to address 5 while reading (1,1) in the same cycle -> old value returned. A re-read 2+ cycles later -> 12'hABC.
- Assert rst_n low with a read in flight and wr_ptr=7 -> rd_valid=0 immediately, wr_ptr=0, and the next write goes to address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants for the pixel frame store and the display timing path that consumes it.
package fb_pkg;

  localparam int unsigned FB_PIX_W = 12;
  localparam int unsigned FB_H_RES = 320;
  localparam int unsigned FB_V_RES = 240;
  localparam logic [FB_PIX_W-1:0] FB_BG_COLOR = 12'h000;

  // Cycles from rd_en to rd_valid; the sync generator delays hsync/vsync by this much.
  localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered, read-first read port.
// There is no reset, so the array and its read register map onto block RAM.
module fb_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // A read and a write to one address in the same cycle return the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// Pixel frame store: streaming raster writes from the UART receiver and 2-cycle (x, y) reads
// for the display path. Out-of-range coordinates return the background colour.
module frame_buffer
  import fb_pkg::*;
#(
  parameter int unsigned        PIX_W    = FB_PIX_W,
  parameter int unsigned        H_RES    = FB_H_RES,
  parameter int unsigned        V_RES    = FB_V_RES,
  parameter int unsigned        X_W      = 9,
  parameter int unsigned        Y_W      = 8,
  parameter logic [PIX_W-1:0]   BG_COLOR = PIX_W'(FB_BG_COLOR),
  parameter bit                 WRAP     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_sof,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_frame_done,
  input  logic             rd_en,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic             rd_valid,
  output logic [PIX_W-1:0] rd_data
);

  localparam int unsigned DEPTH  = H_RES * V_RES;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  // Wide enough for y*H_RES + x over the full coordinate range, in range or not.
  localparam int unsigned LIN_W  = X_W + Y_W + $clog2(H_RES) + 1;

  // ---------------------------------------------------------------- write side
  logic [ADDR_W-1:0] wr_ptr;
  logic              full;
  logic              wr_accept_c;
  logic              wr_last_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [ADDR_W-1:0] wr_ptr_nxt_c;
  logic              full_nxt_c;

  // Write stage feeding the RAM, aligned with the read request register.
  logic              wq_en;
  logic [ADDR_W-1:0] wq_addr;
  logic [PIX_W-1:0]  wq_data;

  // wr_sof redirects a same-cycle pixel to address 0; it cannot unblock a write while full.
  always_comb begin
    wr_accept_c  = wr_valid & ~full;
    wr_addr_c    = wr_sof ? '0 : wr_ptr;
    wr_last_c    = (wr_addr_c == ADDR_W'(DEPTH - 1));
    wr_ptr_nxt_c = wr_addr_c;
    full_nxt_c   = wr_sof ? 1'b0 : full;
    if (wr_accept_c) begin
      if (wr_last_c) begin
        wr_ptr_nxt_c = '0;
        full_nxt_c   = ~WRAP;
      end else begin
        wr_ptr_nxt_c = wr_addr_c + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      full          <= 1'b0;
      wr_ready      <= 1'b1;
      wr_frame_done <= 1'b0;
      wq_en         <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt_c;
      full          <= full_nxt_c;
      wr_ready      <= ~full_nxt_c;
      wr_frame_done <= wr_accept_c & wr_last_c;
      wq_en         <= wr_accept_c;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      wq_addr <= wr_addr_c;
      wq_data <= wr_data;
    end
  end

  // ---------------------------------------------------------------- read side
  logic [LIN_W-1:0]  rd_lin_c;
  logic              rd_oob_c;
  logic              v1;
  logic              v2;
  logic [ADDR_W-1:0] addr1;
  logic              oob1;
  logic              oob2;
  logic              rd_seen;
  logic [PIX_W-1:0]  ram_q;

  always_comb begin
    rd_lin_c = LIN_W'(rd_y) * LIN_W'(H_RES) + LIN_W'(rd_x);
    rd_oob_c = (32'(rd_x) >= H_RES) | (32'(rd_y) >= V_RES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      addr1   <= '0;
      oob1    <= 1'b0;
      oob2    <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      v1 <= rd_en;
      v2 <= v1;
      if (rd_en) begin
        addr1 <= ADDR_W'(rd_lin_c);
        oob1  <= rd_oob_c;
      end
      if (v1) begin
        oob2    <= oob1;
        rd_seen <= 1'b1;
      end
    end
  end

  // RAM read register and oob2 only advance with v1, so rd_data holds between results.
  always_comb begin
    rd_valid = v2;
    if (!rd_seen) begin
      rd_data = '0;
    end else if (oob2) begin
      rd_data = BG_COLOR;
    end else begin
      rd_data = ram_q;
    end
  end

  fb_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wq_en),
    .wr_addr (wq_addr),
    .wr_data (wq_data),
    .rd_en   (v1),
    .rd_addr (addr1),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer on a 4x3 frame with WRAP=0 and a non-zero background colour.
module tb_frame_buffer;

  localparam int unsigned PIX_W = 12;
  localparam int unsigned X_W   = 3;
  localparam int unsigned Y_W   = 2;
  localparam logic [PIX_W-1:0] BG = 12'h5A5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_sof;
  logic             wr_valid;
  logic             wr_ready;
  logic [PIX_W-1:0] wr_data;
  logic             wr_frame_done;
  logic             rd_en;
  logic [X_W-1:0]   rd_x;
  logic [Y_W-1:0]   rd_y;
  logic             rd_valid;
  logic [PIX_W-1:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  frame_buffer #(
    .PIX_W    (PIX_W),
    .H_RES    (4),
    .V_RES    (3),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .BG_COLOR (BG),
    .WRAP     (1'b0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_sof        (wr_sof),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_frame_done (wr_frame_done),
    .rd_en         (rd_en),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PIX_W-1:0] got, input logic [PIX_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [PIX_W-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic rd_check(input int x, input int y, input logic [PIX_W-1:0] exp, input string tag);
    rd_en = 1'b1;
    rd_x  = X_W'(x);
    rd_y  = Y_W'(y);
    step();
    rd_en = 1'b0;
    check({tag, "_early"}, 12'(rd_valid), 12'd0);
    step();
    check({tag, "_valid"}, 12'(rd_valid), 12'd1);
    check({tag, "_data"}, rd_data, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_sof   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    rd_x     = '0;
    rd_y     = '0;
    step();
    step();
    check("rst_wr_ready", 12'(wr_ready), 12'd1);
    check("rst_done", 12'(wr_frame_done), 12'd0);
    check("rst_rd_valid", 12'(rd_valid), 12'd0);
    check("rst_rd_data", rd_data, 12'd0);
    rst_n = 1'b1;
    step();

    // Full frame 001..00C; done pulses only after the last pixel.
    for (int i = 1; i <= 12; i++) begin
      wr_valid = 1'b1;
      wr_data  = 12'(i);
      step();
      check($sformatf("done_%0d", i), 12'(wr_frame_done), 12'(i == 12));
    end
    wr_valid = 1'b0;
    check("full_ready", 12'(wr_ready), 12'd0);
    step();
    check("done_once", 12'(wr_frame_done), 12'd0);

    // Pixel offered while full is dropped.
    wr(12'hFFF);
    check("full_ready2", 12'(wr_ready), 12'd0);
    check("full_done2", 12'(wr_frame_done), 12'd0);

    rd_check(3, 2, 12'h00C, "rd_last");
    rd_check(0, 0, 12'h001, "rd_first");
    rd_check(4, 0, BG, "rd_oob_x");
    rd_check(0, 3, BG, "rd_oob_y");

    // Back-to-back reads, one result per cycle.
    rd_en = 1'b1; rd_x = 3'd0; rd_y = 2'd0;
    step();
    rd_x = 3'd1;
    step();
    check("b2b0_valid", 12'(rd_valid), 12'd1);
    check("b2b0_data", rd_data, 12'h001);
    rd_x = 3'd2;
    step();
    check("b2b1_valid", 12'(rd_valid), 12'd1);
    check("b2b1_data", rd_data, 12'h002);
    rd_en = 1'b0;
    step();
    check("b2b2_valid", 12'(rd_valid), 12'd1);
    check("b2b2_data", rd_data, 12'h003);
    step();
    check("b2b_idle_valid", 12'(rd_valid), 12'd0);
    check("b2b_hold_data", rd_data, 12'h003);

    // Start of frame re-opens writes at address 0.
    wr_sof = 1'b1;
    step();
    wr_sof = 1'b0;
    check("sof_ready", 12'(wr_ready), 12'd1);
    wr(12'h0A1);
    rd_check(0, 0, 12'h0A1, "sof_addr0");
    rd_check(1, 0, 12'h002, "sof_addr1_old");

    // Same-cycle write and read of address 5 returns the old word.
    for (int i = 2; i <= 5; i++) wr(12'(i));
    wr_valid = 1'b1; wr_data = 12'hABC;
    rd_en = 1'b1; rd_x = 3'd1; rd_y = 2'd1;
    step();
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    step();
    check("coll_valid", 12'(rd_valid), 12'd1);
    check("coll_old", rd_data, 12'h006);
    rd_check(1, 1, 12'hABC, "coll_new");

    // Reset with reads in flight and wr_ptr at 7.
    wr(12'h007);
    rd_en = 1'b1; rd_x = 3'd2; rd_y = 2'd1;
    step();
    step();
    rd_en = 1'b0;
    check("pre_rst_valid", 12'(rd_valid), 12'd1);
    check("pre_rst_data", rd_data, 12'h007);
    #2 rst_n = 1'b0;
    #1;
    check("async_rd_valid", 12'(rd_valid), 12'd0);
    check("async_rd_data", rd_data, 12'd0);
    check("async_ready", 12'(wr_ready), 12'd1);
    rst_n = 1'b1;
    step();
    step();
    check("flush_valid", 12'(rd_valid), 12'd0);
    wr(12'h777);
    rd_check(0, 0, 12'h777, "rst_addr0");
    rd_check(3, 1, 12'h008, "rst_addr7_old");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
